// File: rtl/modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer for c = M^e mod n.
// Owns acc/base/n/e registers and drives one external modular multiplier.
module modexp_ctrl #(
    parameter int WIDTH = 2048,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] e,
    input  logic [WIDTH-1:0] n,
    input  logic [WIDTH-1:0] M,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c,
    output logic             mm_start,
    output logic [WIDTH-1:0] mm_a,
    output logic [WIDTH-1:0] mm_b,
    output logic [WIDTH-1:0] mm_n,
    input  logic             mm_done,
    input  logic [WIDTH-1:0] mm_result,
    output logic             busy,
    output logic [2:0]       state_dbg
);

    // Handshakes: a transfer happens on a rising clk edge where valid && ready;
    // out_valid/c hold until out_ready, in_ready is high only in IDLE.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SCAN      = 3'd1,
        SQ_ISSUE  = 3'd2,
        SQ_WAIT   = 3'd3,
        MUL_ISSUE = 3'd4,
        MUL_WAIT  = 3'd5,
        DONE      = 3'd6
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] acc, acc_n;
    logic [WIDTH-1:0] base, base_n;
    logic [WIDTH-1:0] n_r, n_r_n;
    logic [WIDTH-1:0] e_r, e_r_n;
    logic [WIDTH-1:0] c_n;
    logic [WIDTH-1:0] a_r, a_r_n;
    logic [WIDTH-1:0] b_r, b_r_n;
    logic [IDX_W-1:0] idx, idx_n;
    logic             bit_set;
    logic             idx_zero;

    assign bit_set  = e_r[idx];
    assign idx_zero = (idx == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            acc   <= '0;
            base  <= '0;
            n_r   <= '0;
            e_r   <= '0;
            c     <= '0;
            a_r   <= '0;
            b_r   <= '0;
            idx   <= '0;
        end else begin
            state <= state_n;
            acc   <= acc_n;
            base  <= base_n;
            n_r   <= n_r_n;
            e_r   <= e_r_n;
            c     <= c_n;
            a_r   <= a_r_n;
            b_r   <= b_r_n;
            idx   <= idx_n;
        end
    end

    always_comb begin
        state_n = state;
        acc_n   = acc;
        base_n  = base;
        n_r_n   = n_r;
        e_r_n   = e_r;
        c_n     = c;
        a_r_n   = a_r;
        b_r_n   = b_r;
        idx_n   = idx;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    e_r_n   = e;
                    n_r_n   = n;
                    base_n  = M;
                    idx_n   = IDX_W'(WIDTH - 1);
                    state_n = SCAN;
                end
            end
            SCAN: begin
                // Leading zeros of e are skipped one bit per cycle.
                if (bit_set) begin
                    acc_n = base;
                    if (idx_zero) begin
                        c_n     = base;
                        state_n = DONE;
                    end else begin
                        idx_n   = idx - IDX_W'(1);
                        state_n = SQ_ISSUE;
                    end
                end else if (idx_zero) begin
                    c_n     = WIDTH'(1);
                    state_n = DONE;
                end else begin
                    idx_n = idx - IDX_W'(1);
                end
            end
            SQ_ISSUE: begin
                a_r_n   = acc;
                b_r_n   = acc;
                state_n = SQ_WAIT;
            end
            SQ_WAIT: begin
                if (mm_done) begin
                    acc_n = mm_result;
                    if (bit_set) begin
                        state_n = MUL_ISSUE;
                    end else if (idx_zero) begin
                        c_n     = mm_result;
                        state_n = DONE;
                    end else begin
                        idx_n   = idx - IDX_W'(1);
                        state_n = SQ_ISSUE;
                    end
                end
            end
            MUL_ISSUE: begin
                a_r_n   = acc;
                b_r_n   = base;
                state_n = MUL_WAIT;
            end
            MUL_WAIT: begin
                if (mm_done) begin
                    acc_n = mm_result;
                    if (idx_zero) begin
                        c_n     = mm_result;
                        state_n = DONE;
                    end else begin
                        idx_n   = idx - IDX_W'(1);
                        state_n = SQ_ISSUE;
                    end
                end
            end
            DONE: begin
                if (out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Operands come straight from acc/base in the issue cycle, then the
    // captured copies keep them stable until the next issue.
    always_comb begin
        mm_a = a_r;
        mm_b = b_r;
        if (state == SQ_ISSUE) begin
            mm_a = acc;
            mm_b = acc;
        end else if (state == MUL_ISSUE) begin
            mm_a = acc;
            mm_b = base;
        end
    end

    assign mm_n      = n_r;
    assign mm_start  = (state == SQ_ISSUE) || (state == MUL_ISSUE);
    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);
    assign state_dbg = state;

endmodule

// File: tb/tb_modexp_ctrl.sv
// Directed and random bench for modexp_ctrl with a behavioural modular
// multiplier of programmable latency.
module tb_modexp_ctrl;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid, in_ready;
    logic [W-1:0] e, n, M;
    logic         out_valid, out_ready;
    logic [W-1:0] c;
    logic         mm_start;
    logic [W-1:0] mm_a, mm_b, mm_n;
    logic         mm_done;
    logic [W-1:0] mm_result;
    logic         busy;
    logic [2:0]   state_dbg;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    modexp_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .e(e), .n(n), .M(M),
        .out_valid(out_valid), .out_ready(out_ready), .c(c),
        .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b), .mm_n(mm_n),
        .mm_done(mm_done), .mm_result(mm_result),
        .busy(busy), .state_dbg(state_dbg)
    );

    // Behavioural multiplier: mm_done arrives cur_l cycles after mm_start.
    int           cur_l = 5;
    logic         m_done, m_active, inj_done;
    logic [W-1:0] m_res, cap_a, cap_b, cap_n;
    int           m_rem;
    int           pulses = 0;
    int           stab_err = 0;
    logic [W-1:0] log_a[$];
    logic [W-1:0] log_b[$];
    logic [63:0]  prod;

    assign prod      = ({32'b0, mm_a} * {32'b0, mm_b}) % {32'b0, mm_n};
    assign mm_done   = m_done | inj_done;
    assign mm_result = inj_done ? 32'h0000_1234 : m_res;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_done   <= 1'b0;
            m_active <= 1'b0;
            m_rem    <= 0;
            m_res    <= '0;
        end else begin
            m_done <= 1'b0;
            if (mm_start) begin
                pulses <= pulses + 1;
                log_a.push_back(mm_a);
                log_b.push_back(mm_b);
                cap_a    <= mm_a;
                cap_b    <= mm_b;
                cap_n    <= mm_n;
                m_res    <= prod[W-1:0];
                m_rem    <= cur_l - 1;
                m_done   <= (cur_l == 1);
                m_active <= (cur_l != 1);
            end else if (m_active) begin
                m_rem <= m_rem - 1;
                if (m_rem == 1) begin
                    m_done   <= 1'b1;
                    m_active <= 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (reset && m_active && (mm_a !== cap_a || mm_b !== cap_b || mm_n !== cap_n))
            stab_err <= stab_err + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_modexp(input logic [W-1:0] b, input logic [W-1:0] ex,
                                                input logic [W-1:0] md);
        logic [63:0] r;
        r = 64'd1;
        for (int i = W - 1; i >= 0; i--) begin
            r = (r * r) % {32'b0, md};
            if (ex[i]) r = (r * {32'b0, b}) % {32'b0, md};
        end
        return r[W-1:0];
    endfunction

    function automatic int exp_latency(input logic [W-1:0] ex, input int lat);
        int k, pc;
        if (ex == '0) return 1 + W;
        k = 0;
        for (int i = 0; i < W; i++) if (ex[i]) k = i;
        pc = $countones(ex);
        return 1 + (W - k) + (k + pc - 1) * (lat + 1);
    endfunction

    function automatic int exp_pulses(input logic [W-1:0] ex);
        int k;
        if (ex == '0) return 0;
        k = 0;
        for (int i = 0; i < W; i++) if (ex[i]) k = i;
        return k + $countones(ex) - 1;
    endfunction

    task automatic accept_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("out_valid_cleared", out_valid, 0);
        chk("idle_after_accept", busy, 0);
    endtask

    task automatic run_op(input logic [W-1:0] ev, input logic [W-1:0] mv, input logic [W-1:0] nv,
                          input int lat, input bit hold, output logic [W-1:0] cres,
                          output int cyc, output int npulse);
        int p0;
        bit to;
        cur_l = lat;
        p0 = pulses;
        log_a.delete();
        log_b.delete();
        @(negedge clk);
        e = ev; M = mv; n = nv; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cyc = 1;
        to = 1'b0;
        while (!out_valid && !to) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc > 5000) to = 1'b1;
        end
        chk("op_timeout", to, 0);
        cres = c;
        npulse = pulses - p0;
        if (!hold) accept_out();
    endtask

    logic [W-1:0] cr, ev, mv, nv;
    int           cy, np, lat, p0, wd;

    initial begin
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; inj_done = 1'b0;
        e = '0; n = '0; M = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_c", c, 0);
        chk("rst_mm_start", mm_start, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);

        // e = 0: no multiplies, c = 1 after 1+W cycles
        run_op(32'd0, 32'd5, 32'd7, 5, 1'b0, cr, cy, np);
        chk("e0_c", cr, 1);
        chk("e0_pulses", np, 0);
        chk("e0_latency", cy, 1 + W);

        // e = 1: c = M
        run_op(32'd1, 32'd5, 32'd7, 5, 1'b0, cr, cy, np);
        chk("e1_c", cr, 5);
        chk("e1_pulses", np, 0);
        chk("e1_latency", cy, 1 + W);

        // e = 3: square (5*5) then multiply (25%7=4, times 5) -> 6
        run_op(32'd3, 32'd5, 32'd7, 5, 1'b1, cr, cy, np);
        chk("e3_c", cr, 6);
        chk("e3_pulses", np, 2);
        chk("e3_latency", cy, 1 + (W - 1) + 2 * 6);
        chk("e3_sq_a", log_a[0], 5);
        chk("e3_sq_b", log_b[0], 5);
        chk("e3_mul_a", log_a[1], 4);
        chk("e3_mul_b", log_b[1], 5);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = i[0];
            e = 32'd1; M = 32'd2; n = 32'd3;
            @(posedge clk);
            #1;
            chk("hold_c", c, 6);
            chk("hold_out_valid", out_valid, 1);
        end
        in_valid = 1'b0;
        accept_out();

        // e = 65537: 16 squares and one multiply
        run_op(32'd65537, 32'd2, 32'd1000003, 5, 1'b0, cr, cy, np);
        chk("f4_c", cr, ref_modexp(32'd2, 32'd65537, 32'd1000003));
        chk("f4_pulses", np, 17);
        chk("f4_latency", cy, 1 + 16 + 17 * 6);
        chk("f4_operand_stability", stab_err, 0);

        // Reset while waiting on the second multiply of e = 3
        cur_l = 5;
        p0 = pulses;
        @(negedge clk);
        e = 32'd3; M = 32'd5; n = 32'd7; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wd = 0;
        while (pulses - p0 < 2 && wd < 200) begin
            @(posedge clk);
            #1;
            wd++;
        end
        chk("rst_mid_reach", pulses - p0, 2);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_mm_start", mm_start, 0);
        chk("rst_mid_out_valid", out_valid, 0);
        @(negedge clk);
        reset = 1'b1;
        inj_done = 1'b1;
        @(negedge clk);
        inj_done = 1'b0;
        #1;
        chk("stale_done_busy", busy, 0);
        chk("stale_done_c", c, 0);
        run_op(32'd3, 32'd3, 32'd7, 5, 1'b0, cr, cy, np);
        chk("post_rst_c", cr, 6);
        chk("post_rst_pulses", np, 2);

        // Random vectors with per-operation latency
        for (int v = 0; v < 200; v++) begin
            nv = $urandom;
            if (nv < 2) nv = 32'd2;
            mv = $urandom % nv;
            ev = $urandom >> $urandom_range(0, 31);
            lat = $urandom_range(1, 8);
            run_op(ev, mv, nv, lat, 1'b0, cr, cy, np);
            chk("rand_c", cr, ref_modexp(mv, ev, nv));
            chk("rand_pulses", np, exp_pulses(ev));
            chk("rand_latency", cy, exp_latency(ev, lat));
        end
        chk("operand_stability", stab_err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
